// File: rtl/mux_pkg.sv
// Shared definitions for the 8-channel round-robin collector and its arbiter.
// The lock state type is used only when MUX_PKT_LOCK_EN is defined.
package mux_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;

    typedef enum logic {
        ARB,
        LOCKED
    } lock_state_t;

    // Returns {found, index}. The search starts at ptr and wraps modulo NUM_CH.
    function automatic logic [CH_W:0] rr_pick(
        input logic [NUM_CH-1:0] req,
        input logic [CH_W-1:0]   ptr
    );
        logic            found;
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = ptr + CH_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return {found, pick};
    endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational 8-way rotating-priority arbiter.
// It produces a one-hot grant plus the encoded index of the winning requester.
module rr_arbiter_8
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    logic [CH_W:0] pick;

    always_comb begin
        pick  = rr_pick(req, ptr);
        idx   = pick[CH_W-1:0];
        grant = '0;
        if (en && pick[CH_W]) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_8_to_1.sv
// Eight-channel round-robin collector that feeds one registered output stream tagged with its channel index.
// Defining MUX_PKT_LOCK_EN holds the grant on one channel until that channel's in_last word has transferred.
module rr_mux_8_to_1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_sel,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   search_ptr;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   gidx;
    logic              load;
    logic              xfer;
    logic              adv_ptr;
    logic [WIDTH-1:0]  gdata;
    logic              glast;

    assign load     = !out_valid || out_ready;
    assign in_ready = grant;
    assign xfer     = |grant;
    assign gdata    = in_data[gidx*WIDTH +: WIDTH];
    assign glast    = in_last[gidx];

`ifdef MUX_PKT_LOCK_EN
    lock_state_t       state, state_d;
    logic [CH_W-1:0]   lock_ch, lock_ch_d;
    logic [NUM_CH-1:0] lock_mask;

    // The request mask depends only on the registered state, which keeps the grant path acyclic.
    always_comb begin
        lock_mask          = '0;
        lock_mask[lock_ch] = 1'b1;
        req                = in_valid;
        search_ptr         = ptr;
        if (state == LOCKED) begin
            req        = in_valid & lock_mask;
            search_ptr = lock_ch;
        end
    end

    always_comb begin
        state_d   = state;
        lock_ch_d = lock_ch;
        adv_ptr   = 1'b0;
        case (state)
            ARB: begin
                if (xfer) begin
                    if (glast) begin
                        adv_ptr = 1'b1;
                    end else begin
                        state_d   = LOCKED;
                        lock_ch_d = gidx;
                    end
                end
            end
            LOCKED: begin
                if (xfer && glast) begin
                    state_d = ARB;
                    adv_ptr = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB;
            lock_ch <= '0;
        end else begin
            state   <= state_d;
            lock_ch <= lock_ch_d;
        end
    end
`else
    assign req        = in_valid;
    assign search_ptr = ptr;
    assign adv_ptr    = xfer;
`endif

    // Holding enable low during reset keeps any handshake from completing in that cycle.
    rr_arbiter_8 u_arb (
        .req   (req),
        .ptr   (search_ptr),
        .en    (load && !rst),
        .grant (grant),
        .idx   (gidx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_sel   <= gidx;
            out_last  <= glast;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv_ptr) begin
            ptr <= gidx + CH_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_mux_8_to_1.sv
// Self-checking bench for rr_mux_8_to_1 that compares the DUT against a behavioural model of the collector.
// It builds with or without MUX_PKT_LOCK_EN and picks the matching expectations for each build.
module tb_rr_mux_8_to_1;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_last;
    logic [7:0]  in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int tests = 0;
    int fails = 0;
    int glog[$];
    int exp_q[$];
    int last_g;

    // Model of the output register, the rotation pointer, and the optional packet lock.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_sel;
    bit       m_last;
    int       m_ptr;
    bit       m_locked;
    int       m_lock_ch;

    rr_mux_8_to_1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 0;
        m_data    = '0;
        m_sel     = 0;
        m_last    = 0;
        m_ptr     = 0;
        m_locked  = 0;
        m_lock_ch = 0;
    endtask

    // Returns the channel that must be granted this cycle, or -1 when none is.
    function automatic int model_grant();
        if (m_valid && !out_ready) return -1;
`ifdef MUX_PKT_LOCK_EN
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
        for (int k = 0; k < 8; k++) begin
            if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic set_ch(input int c, input logic [7:0] v);
        in_data[c*8 +: 8] = v;
    endtask

    // Entered just after a falling edge with the inputs already driven; it returns at the next falling edge.
    task automatic step();
        int g;
        #1;
        g = model_grant();
        chk("in_ready", {56'd0, in_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk("out_data", {56'd0, out_data}, {56'd0, m_data});
            chk("out_sel", {61'd0, out_sel}, m_sel);
            chk("out_last", {63'd0, out_last}, {63'd0, m_last});
        end
        last_g = g;
        if (g >= 0) begin
            glog.push_back(g);
            m_valid = 1;
            m_data  = in_data[g*8 +: 8];
            m_sel   = g;
            m_last  = in_last[g];
`ifdef MUX_PKT_LOCK_EN
            if (in_last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % 8;
            end else begin
                m_locked  = 1;
                m_lock_ch = g;
            end
`else
            m_ptr = (g + 1) % 8;
`endif
        end else if (!m_valid || out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_log(input string name, input int exp[$]);
        chk({name, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) begin
            chk(name, glog[i], exp[i]);
        end
        glog.delete();
    endtask

    initial begin
        int ch3;
        rst       = 1'b1;
        in_valid  = 8'hFF;
        in_last   = 8'h00;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_in_ready", {56'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_out_sel", {61'd0, out_sel}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        glog.delete();

        for (int i = 0; i < 8; i++) set_ch(i, 8'hA0 + 8'(i));
        in_valid = 8'hFF;
        for (int n = 0; n < 9; n++) step();
        chk("rr_data_wrap", {56'd0, out_data}, 64'hA0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        check_log("rr_order", exp_q);

        in_valid  = 8'h14;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) step();
        chk("bp_hold_sel", {61'd0, out_sel}, 64'd0);
        out_ready = 1'b1;
        step();
        step();
        exp_q = '{2, 4};
        check_log("bp_order", exp_q);

        in_valid = 8'h20;
        step();
        in_valid = 8'h03;
        step();
        step();
        exp_q = '{5, 0, 1};
        check_log("wrap_order", exp_q);

        in_valid = 8'h00;
        step();
        step();
        chk("idle_valid", {63'd0, out_valid}, 64'd0);
        exp_q = {};
        check_log("idle_grants", exp_q);

        ch3 = 0;
        set_ch(5, 8'h50);
        for (int n = 0; n < 10 && ch3 < 3; n++) begin
            in_valid   = 8'h28;
            in_last    = 8'h20;
            in_last[3] = (ch3 == 2);
            set_ch(3, 8'h30 + 8'(ch3));
            step();
            if (last_g == 3) ch3++;
        end
`ifdef MUX_PKT_LOCK_EN
        in_valid = 8'h20;
        step();
        exp_q = '{3, 3, 3, 5};
`else
        exp_q = '{3, 5, 3, 5, 3};
`endif
        check_log("lock_order", exp_q);

        in_valid = 8'hFF;
        in_last  = 8'h00;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {56'd0, in_ready}, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        glog.delete();
        in_valid = 8'h18;
        step();
        exp_q = '{3};
        check_log("post_rst", exp_q);

        for (int n = 0; n < 400; n++) begin
            in_valid  = 8'($urandom) & 8'($urandom);
            in_last   = 8'($urandom_range(0, 255));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 8'h00;
        out_ready = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_mux_8_to_1.md
Name: rr_mux_8_to_1

Overview:
- Eight-channel round-robin collector. It is the gathering counterpart of the team's 1-to-8 demultiplexer.
- Each of 8 input channels offers a WIDTH-bit word with a valid/ready handshake.
- The block grants one channel per cycle and registers the word onto a single output stream.
- The output carries a 3-bit channel tag, so a downstream 1-to-8 demux can route words back by `sel`.

Parameters:
- WIDTH, 8, data width per channel.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  8  per-channel word available
- in_last  in  8  per-channel end-of-packet marker, qualified by in_valid
- in_ready  out  8  per-channel accept; at most one bit high per cycle
- out_data  out  WIDTH  registered selected word
- out_sel  out  3  index of the channel out_data came from
- out_last  out  1  registered copy of the granted channel's in_last
- out_valid  out  1  output word present
- out_ready  in  1  downstream accept

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1:
  - out_valid, out_data, out_sel, out_last = 0.
  - Round-robin pointer ptr = 0.
  - in_ready = 0.
  - Lock state = ARB.
- Load enable: load = !out_valid || out_ready. This gives a single output register with full throughput.
- Grant: when load=1, search channels ptr, ptr+1, …, ptr+7 (mod 8). Grant the first channel i with in_valid[i]=1.
  - in_ready = one-hot(i), combinational. in_ready may depend on in_valid.
  - in_ready = 0 when load=0 or no channel requests.
- On a transfer from channel i at a clock edge:
  - out_data <= channel i data, out_sel <= i, out_last <= in_last[i], out_valid <= 1.
  - ptr <= (i+1) mod 8, so 7 wraps to 0.
- load=1 with no requester: out_valid <= 0. out_data/out_sel hold their previous values (don't-care).
- load=0 (out_valid=1, out_ready=0): output and ptr hold; all in_ready = 0.
- Latency: 1 cycle from input transfer to out_valid.
- Sustained throughput: 1 word per cycle while out_ready=1.
- All 8 channels continuously valid: grants rotate 0,1,…,7,0. No channel is granted twice before every other requester has been granted once.
- A channel that drops in_valid before being granted is skipped with no side effect.
- Reset asserted mid-stream: the buffered word is discarded and no handshake completes in that cycle.
- out_sel is always in 0..7. There is no invalid-select case.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- Defined: packet lock, a two-state FSM (ARB, LOCKED).
  - In ARB, a transfer from channel i with in_last[i]=0 moves to LOCKED(i) and does not advance ptr.
  - In LOCKED(i), only channel i is eligible; other valids are ignored.
  - The transfer with in_last[i]=1 returns to ARB and sets ptr <= (i+1) mod 8.
  - A single-word packet (last=1 in ARB) behaves as unlocked arbitration.
- Undefined: arbitration is strictly per word, and in_last is only passed through to out_last.
- Ports are identical in both builds.

Decomposition:
- Shared package mux_pkg:
  - NUM_CH = 8, CH_W = 3.
  - Lock state enum {ARB, LOCKED}.
  - Function for rotating priority search.
- One sub-module: rr_arbiter_8. Inputs: 8-bit request vector, 3-bit ptr, enable. Outputs: one-hot grant and 3-bit index. Purely combinational.
- Lock FSM, ptr, and output register stay in the top module.

Test Plan:
- Reset: rst=1 mid-transfer with out_valid=1 → out_valid=0, in_ready=0, ptr=0 immediately (no clock edge needed); first grant after release goes to the lowest valid channel ≥0.
- Round robin: in_valid=8'hFF, out_ready=1, data[i]=8'hA0+i → out_sel sequence 0..7 then 0, out_data A0..A7, one word per cycle, latency 1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=8'h14 → output holds; in_ready=0 throughout; on release, channel 2 is accepted, then channel 4.
- Wrap and skip: ptr=6, in_valid=8'h03 → channel 0 granted, ptr becomes 1; next cycle channel 1 granted.
- Idle: in_valid=0, out_ready=1 → out_valid falls to 0 after the last word; no in_ready asserted.
- MUX_PKT_LOCK_EN: channel 3 sends 3 words (last on the third) while channel 5 is valid throughout → out_sel 3,3,3 then 5. Without the macro → 3,5,3,5,3.
